bcd_addsub_serial: RTL
======================

BCD_ADDSUB_SERIAL -- requirements
Module: bcd_addsub_serial

Interface
REQ-001 Parameter: DIGITS, default 4, number of BCD digits per operand; legal range 1..16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  1  0 = add, 1 = subtract (a - b).
REQ-006 a  input  4*DIGITS  packed BCD operand A; digit 0 is bits [3:0].
REQ-007 b  input  4*DIGITS  packed BCD operand B.
REQ-008 cin  input  1  carry-in for add; borrow-in for subtract.
REQ-009 busy  output  1  high while a digit sequence is in progress.
REQ-010 done  output  1  one-cycle pulse when result, cout and invalid are valid.
REQ-011 result  output  4*DIGITS  packed BCD result, held until the next accepted start.
REQ-012 cout  output  1  add: decimal carry-out; subtract: 1 = no borrow (a >= b + cin).
REQ-013 invalid  output  1  any digit of the latched a or b exceeded 9.

Function
REQ-014 States SHALL be IDLE and RUN; start=1 in IDLE moves to RUN and latches a, b, op, cin; digit index is set to 0.
REQ-015 start SHALL be ignored while in RUN; operand changes during RUN SHALL not affect the result.
REQ-016 RUN SHALL process one digit per cycle, LSD first, writing result digit i on the i-th edge after acceptance.
REQ-017 The edge writing digit DIGITS-1 SHALL set done=1 for exactly one cycle, update cout and invalid, and return to IDLE; latency is DIGITS edges from the accepting edge.
REQ-018 busy SHALL be 1 from the edge after acceptance through the edge writing the last digit, then 0.
REQ-019 Add: per digit s = a_i + b_i + c; if s > 9 then digit = s + 6 mod 16, carry out 1; else digit = s, carry out 0; initial c = cin.
REQ-020 Subtract: b_i SHALL be replaced by its nine's complement (9 - b_i); initial c = NOT cin; the add rule of REQ-019 then applies.
REQ-021 Subtract with a negative result SHALL produce the ten's complement in result with cout=0.
REQ-022 invalid SHALL be evaluated over all digits of a and b at acceptance; when set, result SHALL be all zeros and cout 0 at done.
REQ-023 start=1 during the done-pulse cycle SHALL be accepted (IDLE), giving back-to-back operations with no idle gap.
REQ-024 result, cout and invalid SHALL stay stable from done until the edge writing digit 0 of the next operation; result digits SHALL update progressively during RUN.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE with busy=0, done=0, result=0, cout=0, invalid=0, in any state.
REQ-026 Reset during RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-027 If rst and start are both 1 at the same edge, rst SHALL win and start is dropped.

Structure
REQ-028 Shared package bcd_pkg SHALL hold the IDLE/RUN state typedef, the constant DIGIT_W = 4 and the constant BCD_MAX = 9.
REQ-029 A combinational sub-module bcd_digit_adder SHALL implement the per-digit rule of REQ-019 (inputs: two digits and a carry; outputs: a digit and a carry).
REQ-030 The top level SHALL contain one instance of bcd_digit_adder, a digit-index counter of width clog2(DIGITS) plus 1, and the operand shift registers.

Verification
REQ-031 DIGITS=4, add, a=1234, b=2345, cin=0 -> result 3579, cout 0, done exactly 4 edges after start.
REQ-032 DIGITS=4, add, a=8976, b=7894, cin=0 -> result 6870, cout 1; then a=9999, b=9999, cin=1 -> result 9999, cout 1.
REQ-033 DIGITS=4, subtract, a=0005, b=0007, cin=0 -> result 9998, cout 0; a=0100, b=0001 -> result 0099, cout 1.
REQ-034 DIGITS=4, a=12A4 -> invalid 1, result 0000, cout 0; start held high through done -> second operation accepted in the done cycle.
REQ-035 DIGITS=8, add, a=99999999, b=00000001 -> result 00000000, cout 1, done 8 edges after start; rst pulsed at edge 3 of a repeat run -> busy 0, no done pulse.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD add/subtract unit.
package bcd_pkg;
   localparam int DIGIT_W = 4;
   localparam int BCD_MAX = 9;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;
endpackage

// File: rtl/bcd_digit_adder.sv
// One BCD digit of addition: binary sum with a +6 correction when it leaves 0..9.
module bcd_digit_adder
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic               ci,
   output logic [DIGIT_W-1:0] s,
   output logic               co
);

   logic [DIGIT_W:0] raw;

   always_comb begin
      raw = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, ci};
      co  = (raw > (DIGIT_W+1)'(BCD_MAX));
      s   = co ? raw[DIGIT_W-1:0] + DIGIT_W'(6) : raw[DIGIT_W-1:0];
   end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial BCD adder/subtractor: one digit per clock, least significant first.
// Subtraction adds the nine's complement of b with the carry seeded by NOT cin.
module bcd_addsub_serial
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  op,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic                  cin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   result,
   output logic                  cout,
   output logic                  invalid
);

   localparam int W     = DIGIT_W * DIGITS;
   localparam int IDX_W = $clog2(DIGITS) + 1;

   state_t             state, state_nxt;
   logic [W-1:0]       a_sh, b_sh, b_eff;
   logic [IDX_W-1:0]   idx;
   logic               carry, carry_nxt, inv_l, in_bad;
   logic [DIGIT_W-1:0] sum_d;
   logic               accept, last;

   // Operand screening and nine's complement are done once, at acceptance.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      in_bad = 1'b0;
      b_eff  = b;
      for (int i = 0; i < DIGITS; i++) begin
         if (a[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX) ||
             b[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX))
            in_bad = 1'b1;
         if (op)
            b_eff[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(BCD_MAX) - b[i*DIGIT_W +: DIGIT_W];
      end
   end

   assign accept = (state == IDLE) && start;
   assign last   = (state == RUN) && (idx == IDX_W'(DIGITS - 1));
   assign busy   = (state == RUN);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   bcd_digit_adder u_digit (
      .a  (a_sh[DIGIT_W-1:0]),
      .b  (b_sh[DIGIT_W-1:0]),
      .ci (carry),
      .s  (sum_d),
      .co (carry_nxt)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         done    <= 1'b0;
         result  <= '0;
         cout    <= 1'b0;
         invalid <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= last;
         if (state == RUN) begin
            result[idx*DIGIT_W +: DIGIT_W] <= inv_l ? '0 : sum_d;
            if (last) begin
               cout    <= ~inv_l & carry_nxt;
               invalid <= inv_l;
            end
         end
      end
   end

   // NOTE: the datapath is not reset; it is only observed in RUN, which is always entered through accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_sh  <= a;
         b_sh  <= b_eff;
         carry <= op ? ~cin : cin;
         inv_l <= in_bad;
         idx   <= '0;
      end else if (state == RUN) begin
         a_sh  <= a_sh >> DIGIT_W;
         b_sh  <= b_sh >> DIGIT_W;
         carry <= carry_nxt;
         idx   <= idx + IDX_W'(1);
      end
   end

endmodule
